// File: rtl/instr_mem_prog_if.sv
// Fetch and word-serial load bus of the host-loadable instruction memory.
// The CPU/host side uses the master modport and the memory uses the slave modport.
interface instr_mem_prog_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] pc;
  logic              fetch_en;
  logic [DATA_W-1:0] instruction;
  logic              instr_valid;
  logic              addr_err;
  logic              load_start;
  logic              load_abort;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;
  logic              load_busy;
  logic              load_done;

  modport master (
    output pc, fetch_en, load_start, load_abort, load_valid, load_data,
    input  instruction, instr_valid, addr_err, load_ready, load_busy, load_done
  );

  modport slave (
    input  pc, fetch_en, load_start, load_abort, load_valid, load_data,
    output instruction, instr_valid, addr_err, load_ready, load_busy, load_done
  );
endinterface

// File: rtl/instr_mem_prog.sv
// Host-loadable instruction memory with a registered fetch port.
// A loader FSM writes words 0..DEPTH-1 serially. Fetches are refused while a load is in progress.
module instr_mem_prog #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 16
) (
  input logic              clk,
  input logic              reset,
  instr_mem_prog_if.slave  bus
);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(2 * DEPTH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_LOAD = 1'b1} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_wptr;
  logic              r_load_ready;
  logic              r_load_busy;
  logic              r_load_done;
  logic [DATA_W-1:0] r_instruction;
  logic              r_instr_valid;
  logic              r_addr_err;

  // Power-up image is all zeros (NOP). Reset leaves the array untouched.
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};

  logic             w_accept;
  logic             w_addr_ok;
  logic [IDX_W-1:0] w_idx;
  logic             w_write;

  assign w_idx     = bus.pc[IDX_W:1];
  assign w_addr_ok = ({1'b0, bus.pc} < LIMIT) && !bus.pc[0];
  assign w_accept  = bus.fetch_en && (r_state == S_IDLE);
  // An abort wins over a handshake in the same cycle.
  assign w_write   = (r_state == S_LOAD) && bus.load_valid && !bus.load_abort;

  // Loader FSM. The ready, busy and done outputs are registered decodes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_wptr       <= '0;
      r_load_ready <= 1'b0;
      r_load_busy  <= 1'b0;
      r_load_done  <= 1'b0;
    end else begin
      r_load_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.load_start) begin
            r_state      <= S_LOAD;
            r_wptr       <= '0;
            r_load_ready <= 1'b1;
            r_load_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.load_abort) begin
            r_state      <= S_IDLE;
            r_load_ready <= 1'b0;
            r_load_busy  <= 1'b0;
          end else if (bus.load_valid) begin
            r_wptr <= r_wptr + IDX_W'(1);
            if (r_wptr == LAST) begin
              r_state      <= S_IDLE;
              r_load_ready <= 1'b0;
              r_load_busy  <= 1'b0;
              r_load_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_load_ready <= 1'b0;
          r_load_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_wptr] <= bus.load_data;
    end
  end

  // Registered fetch. When no fetch is accepted, the word and the error flag hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instruction <= '0;
      r_instr_valid <= 1'b0;
      r_addr_err    <= 1'b0;
    end else begin
      r_instr_valid <= w_accept;
      if (w_accept) begin
        if (w_addr_ok) begin
          r_instruction <= r_mem[w_idx];
          r_addr_err    <= 1'b0;
        end else begin
          r_instruction <= '0;
          r_addr_err    <= 1'b1;
        end
      end
    end
  end

  assign bus.instruction = r_instruction;
  assign bus.instr_valid = r_instr_valid;
  assign bus.addr_err    = r_addr_err;
  assign bus.load_ready  = r_load_ready;
  assign bus.load_busy   = r_load_busy;
  assign bus.load_done   = r_load_done;
endmodule

// File: doc/instr_mem_prog.md
# instr_mem_prog

Parametrised, host-loadable instruction memory for the 16-bit single-cycle/multi-cycle CPU. It replaces the fixed, combinational instruction ROM with the following:
- a synchronous (registered) fetch port with a valid flag and address-error detection;
- a word-serial load port driven by a loader FSM, so that programs can be written at run time instead of being hard-coded.

The block sits between the PC register and the instruction decoder. The load port is driven by a host or testbench.

## Interface
- DATA_W, 16, instruction width in bits
- ADDR_W, 16, PC width in bits (PC is a byte address)
- DEPTH, 16, number of instruction words; power of two, 2 ≤ DEPTH ≤ 2^(ADDR_W-1)
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state except memory array
- pc  in  ADDR_W  byte address of instruction to fetch
- fetch_en  in  1  fetch request for this cycle
- instruction  out  DATA_W  registered fetched word
- instr_valid  out  1  instruction holds the result of last cycle's accepted fetch
- addr_err  out  1  last accepted fetch was out of range or misaligned
- load_start  in  1  begin loading the memory from word 0
- load_abort  in  1  terminate an in-progress load
- load_valid  in  1  load_data is valid
- load_data  in  DATA_W  word to write
- load_ready  out  1  block accepts load_data this cycle
- load_busy  out  1  loader is in LOAD state
- load_done  out  1  one-cycle pulse: full image written

## Operation
- Word index = pc[log2(DEPTH):1]; pc[0] must be 0.
- Range check: pc < 2*DEPTH, evaluated at ADDR_W+1 bits; no truncation.
- Memory array DATA_W x DEPTH initialises to all zeros at power-up; zero decodes as NOP.
  - Reset never modifies array contents.
- Loader FSM states:
  - IDLE:
    - load_start=1 → LOAD, write pointer wptr ← 0.
    - load_abort is ignored.
  - LOAD:
    - load_ready=1.
    - Each cycle with load_valid & load_ready: mem[wptr] ← load_data, wptr ← wptr+1.
    - Handshake with wptr = DEPTH-1 → IDLE; load_done=1 for exactly the next cycle.
    - load_abort=1 → IDLE with no write that cycle (abort wins over a simultaneous handshake). Words already written remain; load_done stays 0.
    - load_start is ignored.
- Fetch is accepted only when fetch_en=1 and state=IDLE. Next cycle:
  - in range and aligned: instruction = mem[index], addr_err=0, instr_valid=1;
  - out of range or pc[0]=1: instruction = 0, addr_err=1, instr_valid=1.
- fetch_en=1 while in LOAD: not accepted; next cycle instr_valid=0, instruction and addr_err hold. The CPU stalls on !instr_valid.
- fetch_en=0: next cycle instr_valid=0, instruction and addr_err hold.
- load_start and fetch_en in the same IDLE cycle: the fetch is accepted and reads the pre-load contents; state goes to LOAD next cycle.

## Timing
- Reset values:
  - instruction=0, instr_valid=0, addr_err=0;
  - load_ready=0, load_busy=0, load_done=0;
  - state IDLE, wptr=0.
- Reset takes effect immediately, without a clock.
- Reset mid-load: back to IDLE. Words written before reset persist; no load_done.
- Fetch latency: 1 cycle, pc/fetch_en at edge N → outputs valid after edge N+1. Back-to-back fetches sustain 1 per cycle.
- load_ready and load_busy are registered state decodes:
  - both rise the cycle after load_start is sampled;
  - both fall the cycle after the final handshake or abort.
- Full load takes DEPTH handshake cycles minimum, plus 1 entry cycle.
- load_done is asserted in the same cycle load_busy falls after a completed load.
- No read/write collision is possible, because fetches are never accepted during LOAD.

## Test plan
- Reset, then fetch pc=0,2,…,30 (defaults) → each instr_valid=1, instruction=0x0000, addr_err=0. Verify all outputs are 0 while reset is held.
- load_start, then 16 words 0x1000+i with load_valid always 1:
  - load_busy for 16 cycles, load_done pulse once;
  - then fetch pc=2*i → 0x1000+i for i=0..15.
- Fetch pc=32 → instruction=0, addr_err=1, instr_valid=1. Fetch pc=0xFFFE → same. Fetch pc=3 → instruction=0, addr_err=1.
- fetch_en=1 held through a load with random load_valid gaps:
  - instr_valid=0 for every cycle in LOAD;
  - the first fetch after load_done returns the new contents;
  - wptr advances only on handshakes.
- After a full load of 0x1000+i: new load of 0xA000+i, load_abort after 5 handshakes → pc=0..8 returns 0xA000..0xA004; pc=10 returns 0x1005; load_done never pulses.
- Assert reset after 3 words of a load → all outputs 0 immediately. Memory words 0..2 hold the new data, word 3 keeps the old data. A fresh load_start restarts at wptr=0.
